// File: rtl/pll_lock_supervisor.sv
// Reset sequencer for a fabric PLL: pulses the PLL reset, retries on lock timeout,
// waits for a stable lock window before releasing system reset and tracks lock losses.
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] loss_count,
    output logic [2:0]       state_o
);

    localparam int unsigned PH_MAX = (RST_CYCLES > LOCK_TIMEOUT)
        ? ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES)
        : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
    localparam int unsigned PH_W = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int unsigned RT_W = $clog2(MAX_RETRIES + 1);

    localparam logic [PH_W-1:0] RST_LAST     = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0] TIMEOUT_LAST = PH_W'(LOCK_TIMEOUT - 1);
    localparam logic [PH_W-1:0] STABLE_LAST  = PH_W'(STABLE_CYCLES - 1);
    localparam logic [RT_W-1:0] RETRY_LAST   = RT_W'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [RT_W-1:0]  retry_q, retry_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             lock_meta, locked_s;
    logic             pll_rst_d, sys_rst_d, ready_d, fault_d;

    // Two-flop synchronizer for the asynchronous PLL lock indication
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            locked_s  <= lock_meta;
        end
    end

    // Next-state, shared phase counter, retry/loss counters and output decode
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            PLL_RESET: begin
                phase_d = phase_q + PH_W'(1);
                if (phase_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                phase_d = phase_q + PH_W'(1);
                if (locked_s) begin
                    state_d = STABLE;
                end else if (phase_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + RT_W'(1);
                    state_d = (retry_q == RETRY_LAST) ? FAULT : PLL_RESET;
                end
            end
            STABLE: begin
                phase_d = phase_q + PH_W'(1);
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (phase_q == STABLE_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = PLL_RESET;
                    if (loss_q != '1) begin
                        loss_d = loss_q + CNT_W'(1);
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = PLL_RESET;
            end
        endcase

        // Every state change restarts the phase timer
        if (state_d != state_q) begin
            phase_d = '0;
        end

        pll_rst_d = (state_d == PLL_RESET) || (state_d == FAULT);
        sys_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
        fault_d   = (state_d == FAULT);
    end

    // State and registered outputs
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= PLL_RESET;
            phase_q <= '0;
            retry_q <= '0;
            loss_q  <= '0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
            pll_rst <= pll_rst_d;
            sys_rst <= sys_rst_d;
            ready   <= ready_d;
            fault   <= fault_d;
        end
    end

    assign loss_count = loss_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: table of {inputs, cycle count, expected outputs}
// rows plus a few bounded latency measurements.
module tb_pll_lock_supervisor;

    localparam int unsigned CNT_W = 2;

    logic             refclk = 1'b0;
    logic             rst;
    logic             pll_locked;
    logic             pll_rst;
    logic             sys_rst;
    logic             ready;
    logic             fault;
    logic [CNT_W-1:0] loss_count;
    logic [2:0]       state_o;

    typedef struct {
        logic       rst;
        logic       lk;
        int         n;
        logic [2:0] st;
        logic       prst;
        logic       srst;
        logic       rdy;
        logic       flt;
        logic [1:0] loss;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2),
        .CNT_W         (CNT_W)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .loss_count (loss_count),
        .state_o    (state_o)
    );

    task automatic add(input logic r, input logic lk, input int n, input logic [2:0] st,
                       input logic prst, input logic srst, input logic rdy, input logic flt,
                       input logic [1:0] loss);
        vec_t v;
        v.rst  = r;
        v.lk   = lk;
        v.n    = n;
        v.st   = st;
        v.prst = prst;
        v.srst = srst;
        v.rdy  = rdy;
        v.flt  = flt;
        v.loss = loss;
        vecs.push_back(v);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return pll_rst;
            default: return ready;
        endcase
    endfunction

    // Edges until the selected output reads val; -1 if the bound expires
    task automatic edges_until(input int sel, input logic val, output int n);
        bit hit;
        hit = 1'b0;
        n   = -1;
        for (int k = 1; k <= 200 && !hit; k++) begin
            @(posedge refclk);
            #1;
            if (sig_of(sel) === val) begin
                n   = k;
                hit = 1'b1;
            end
        end
    endtask

    initial begin
        logic [8:0] act;
        logic [8:0] exp;
        int         n;

        rst        = 1'b1;
        pll_locked = 1'b0;

        // Clean bring-up: lock rises 3 cycles after pll_rst falls
        add(1, 0, 2,  0, 1, 1, 0, 0, 0);
        add(0, 0, 3,  0, 1, 1, 0, 0, 0);
        add(0, 0, 1,  1, 0, 1, 0, 0, 0);
        add(0, 0, 3,  1, 0, 1, 0, 0, 0);
        add(0, 1, 2,  1, 0, 1, 0, 0, 0);
        add(0, 1, 1,  2, 0, 1, 0, 0, 0);
        add(0, 1, 7,  2, 0, 1, 0, 0, 0);
        add(0, 1, 1,  3, 0, 0, 1, 0, 0);

        // Acquisition glitch after 5 STABLE cycles
        add(1, 0, 1,  0, 1, 1, 0, 0, 0);
        add(0, 0, 4,  1, 0, 1, 0, 0, 0);
        add(0, 1, 3,  2, 0, 1, 0, 0, 0);
        add(0, 1, 4,  2, 0, 1, 0, 0, 0);
        add(0, 0, 1,  2, 0, 1, 0, 0, 0);
        add(0, 1, 1,  2, 0, 1, 0, 0, 0);
        add(0, 1, 1,  1, 0, 1, 0, 0, 0);
        add(0, 1, 1,  2, 0, 1, 0, 0, 0);
        add(0, 1, 7,  2, 0, 1, 0, 0, 0);
        add(0, 1, 1,  3, 0, 0, 1, 0, 0);

        // Timeout retry, with a lock blip ignored during PLL_RESET
        add(1, 0, 1,  0, 1, 1, 0, 0, 0);
        add(0, 1, 1,  0, 1, 1, 0, 0, 0);
        add(0, 0, 2,  0, 1, 1, 0, 0, 0);
        add(0, 0, 1,  1, 0, 1, 0, 0, 0);
        add(0, 0, 19, 1, 0, 1, 0, 0, 0);
        add(0, 0, 1,  0, 1, 1, 0, 0, 0);
        add(0, 0, 3,  0, 1, 1, 0, 0, 0);
        add(0, 0, 1,  1, 0, 1, 0, 0, 0);
        add(0, 1, 2,  1, 0, 1, 0, 0, 0);
        add(0, 1, 1,  2, 0, 1, 0, 0, 0);
        add(0, 1, 8,  3, 0, 0, 1, 0, 0);

        // Fault after two timeouts, absorbing until rst
        add(1, 0, 1,  0, 1, 1, 0, 0, 0);
        add(0, 0, 4,  1, 0, 1, 0, 0, 0);
        add(0, 0, 20, 0, 1, 1, 0, 0, 0);
        add(0, 0, 4,  1, 0, 1, 0, 0, 0);
        add(0, 0, 19, 1, 0, 1, 0, 0, 0);
        add(0, 0, 1,  4, 1, 1, 0, 1, 0);
        add(0, 1, 10, 4, 1, 1, 0, 1, 0);
        add(1, 1, 1,  0, 1, 1, 0, 0, 0);

        // Reset while in STABLE
        add(0, 1, 4,  1, 0, 1, 0, 0, 0);
        add(0, 1, 3,  2, 0, 1, 0, 0, 0);
        add(1, 1, 1,  0, 1, 1, 0, 0, 0);

        // Lock loss in RUN four times, count saturates at 3
        add(1, 0, 1,  0, 1, 1, 0, 0, 0);
        add(0, 1, 4,  1, 0, 1, 0, 0, 0);
        add(0, 1, 9,  3, 0, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] prev;
            logic [1:0] lc;
            prev = 2'(k);
            lc   = (k < 3) ? 2'(k + 1) : 2'd3;
            add(0, 0, 2, 3, 0, 0, 1, 0, prev);
            add(0, 0, 1, 0, 1, 1, 0, 0, lc);
            add(0, 1, 4, 1, 0, 1, 0, 0, lc);
            add(0, 1, 9, 3, 0, 0, 1, 0, lc);
        end

        // Reset while in RUN clears loss_count
        add(1, 1, 1,  0, 1, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst        = vecs[i].rst;
            pll_locked = vecs[i].lk;
            repeat (vecs[i].n) @(posedge refclk);
            #1;
            exp = {vecs[i].st, vecs[i].prst, vecs[i].srst, vecs[i].rdy, vecs[i].flt, vecs[i].loss};
            act = {state_o, pll_rst, sys_rst, ready, fault, loss_count};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL vec%0d {st,pll_rst,sys_rst,ready,fault,loss}: got %b, expected %b",
                         i, act, exp);
            end
        end

        // Measured latencies from a fresh reset release
        rst        = 1'b0;
        pll_locked = 1'b0;
        edges_until(0, 1'b0, n);
        check_int("pll_rst_width", n, 4);
        pll_locked = 1'b1;
        edges_until(1, 1'b1, n);
        check_int("lock_to_ready", n, 11);
        check_int("sys_rst_in_run", int'(sys_rst), 0);
        pll_locked = 1'b0;
        edges_until(1, 1'b0, n);
        check_int("loss_to_not_ready", n, 3);
        check_int("sys_rst_after_loss", int'(sys_rst), 1);
        check_int("loss_count_after_loss", int'(loss_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
